// File: rtl/divider_dividend_reconstructor_seq_if.sv
// Operand/result handshake bundle for the dividend reconstructor.
// Master drives operands and result-ready; slave is the reconstructor.
interface divider_dividend_reconstructor_seq_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     q;
    logic [WIDTH-1:0]     d;
    logic [WIDTH-1:0]     r;
    logic [2*WIDTH-1:0]   n_ref;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   n_rec;
    logic [2*WIDTH:0]     err;
    logic                 d_zero;

    modport master (
        output in_valid, q, d, r, n_ref, out_ready,
        input  in_ready, out_valid, n_rec, err, d_zero
    );

    modport slave (
        input  in_valid, q, d, r, n_ref, out_ready,
        output in_ready, out_valid, n_rec, err, d_zero
    );
endinterface

// File: rtl/divider_dividend_reconstructor_seq.sv
// Rebuilds n = q*d + r by sequential shift-add over WIDTH cycles
// and reports the signed error against the reference dividend.
module divider_dividend_reconstructor_seq #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    divider_dividend_reconstructor_seq_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int NW = 2 * WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_q;
    logic [NW-1:0]    r_d;
    logic [NW-1:0]    r_nref;
    logic [NW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [NW-1:0]    r_n_rec;
    logic [NW:0]      r_err;
    logic             r_d_zero;

    logic [NW-1:0]    w_addend;
    logic [NW-1:0]    w_acc_next;
    logic             w_last;

    // Partial product for the current quotient bit
    always_comb begin
        w_addend   = r_q[r_cnt] ? (r_d << r_cnt) : '0;
        w_acc_next = r_acc + w_addend;
        w_last     = (r_cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_nref      <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_n_rec     <= '0;
            r_err       <= '0;
            r_d_zero    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_state  <= S_MUL;
                        r_q      <= bus.q;
                        r_d      <= {{WIDTH{1'b0}}, bus.d};
                        r_nref   <= bus.n_ref;
                        r_acc    <= {{WIDTH{1'b0}}, bus.r};
                        r_cnt    <= '0;
                        r_d_zero <= (bus.d == '0);
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_cnt       <= '0;
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_n_rec     <= w_acc_next;
                        r_err       <= {1'b0, r_nref} - {1'b0, w_acc_next};
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.n_rec     = r_n_rec;
    assign bus.err       = r_err;
    assign bus.d_zero    = r_d_zero;
endmodule

// File: tb/tb_divider_dividend_reconstructor_seq.sv
// Randomised self-checking bench for the dividend reconstructor.
// Expected values come from plain integer arithmetic q*d+r.
module tb_divider_dividend_reconstructor_seq;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    divider_dividend_reconstructor_seq_if #(.WIDTH(W)) bus ();

    divider_dividend_reconstructor_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_rec(input logic [W-1:0] q,
                                               input logic [W-1:0] d,
                                               input logic [W-1:0] r);
        int v;
        v = int'(q) * int'(d) + int'(r);
        return v[2*W-1:0];
    endfunction

    function automatic logic [2*W:0] ref_err(input logic [2*W-1:0] nref,
                                             input logic [W-1:0] q,
                                             input logic [W-1:0] d,
                                             input logic [W-1:0] r);
        int v;
        v = int'(nref) - (int'(q) * int'(d) + int'(r));
        return v[2*W:0];
    endfunction

    task automatic start_op(input logic [W-1:0] q, input logic [W-1:0] d,
                            input logic [W-1:0] r, input logic [2*W-1:0] nref);
        bus.q        = q;
        bus.d        = d;
        bus.r        = r;
        bus.n_ref    = nref;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.q        = W'($urandom);
        bus.d        = W'($urandom);
        bus.r        = W'($urandom);
        bus.n_ref    = (2*W)'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [W-1:0] q,
                             input logic [W-1:0] d, input logic [W-1:0] r,
                             input logic [2*W-1:0] nref);
        int lat;
        logic [2*W-1:0] e_rec;
        logic [2*W:0]   e_err;
        logic           e_dz;
        e_rec = ref_rec(q, d, r);
        e_err = ref_err(nref, q, d, r);
        e_dz  = (d == 0);
        start_op(q, d, r, nref);
        wait_done(lat);
        n_total++;
        if (lat !== W) $display("FAIL %s latency: got %0d exp %0d", nm, lat, W);
        else n_pass++;
        n_total++;
        if (bus.n_rec !== e_rec)
            $display("FAIL %s n_rec: got %h exp %h", nm, bus.n_rec, e_rec);
        else n_pass++;
        n_total++;
        if (bus.err !== e_err)
            $display("FAIL %s err: got %h exp %h", nm, bus.err, e_err);
        else n_pass++;
        n_total++;
        if (bus.d_zero !== e_dz)
            $display("FAIL %s d_zero: got %b exp %b", nm, bus.d_zero, e_dz);
        else n_pass++;
        ack();
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.q         = '0;
        bus.d         = '0;
        bus.r         = '0;
        bus.n_ref     = '0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.out_valid, bus.n_rec, bus.err, bus.d_zero} !== '0)
            $display("FAIL reset_outputs: got ov=%b n_rec=%h err=%h dz=%b exp all 0",
                     bus.out_valid, bus.n_rec, bus.err, bus.d_zero);
        else n_pass++;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1)
            $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready);
        else n_pass++;
    endtask

    task automatic test_vectors();
        run_check("vec1", 8'h10, 8'h0F, 8'h03, 16'h00F3);
        run_check("vec2_max", 8'hFF, 8'hFF, 8'hFF, 16'hFFFF);
        run_check("vec3_dzero", 8'h00, 8'h00, 8'h00, 16'hFFFF);
        run_check("vec4_neg", 8'h05, 8'h03, 8'h00, 16'h0000);
        n_total++;
        if (ref_err(16'h0000, 8'h05, 8'h03, 8'h00) !== 17'h1FFF1 ||
            bus.err !== 17'h1FFF1)
            $display("FAIL vec4_err_held: got %h exp 1fff1", bus.err);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] q, d, r;
            logic [2*W-1:0] nref;
            q    = W'($urandom);
            d    = (i % 7 == 0) ? '0 : W'($urandom);
            r    = W'($urandom);
            nref = (i % 3 == 0) ? ref_rec(q, d, r) : (2*W)'($urandom);
            run_check("random", q, d, r, nref);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [2*W-1:0] e_rec;
        logic [2*W:0]   e_err;
        e_rec = ref_rec(8'hA5, 8'h3C, 8'h11);
        e_err = ref_err(16'h1234, 8'hA5, 8'h3C, 8'h11);
        start_op(8'hA5, 8'h3C, 8'h11, 16'h1234);
        wait_done(lat);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = c[0];
            bus.q        = 8'h01;
            bus.d        = 8'h01;
            @(posedge clk);
            #1;
            n_total++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.n_rec !== e_rec || bus.err !== e_err)
                $display("FAIL hold_cycle%0d: got ov=%b ir=%b n_rec=%h err=%h exp ov=1 ir=0 n_rec=%h err=%h",
                         c, bus.out_valid, bus.in_ready, bus.n_rec, bus.err, e_rec, e_err);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        ack();
        n_total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 ||
            bus.n_rec !== e_rec || bus.err !== e_err)
            $display("FAIL hold_release: got ov=%b ir=%b n_rec=%h err=%h exp ov=0 ir=1 n_rec=%h err=%h",
                     bus.out_valid, bus.in_ready, bus.n_rec, bus.err, e_rec, e_err);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        start_op(8'hFF, 8'h00, 8'h07, 16'h0000);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.out_valid, bus.n_rec, bus.err, bus.d_zero, bus.in_ready} !== 35'h1)
            $display("FAIL reset_mid: got ov=%b n_rec=%h err=%h dz=%b ir=%b exp 0,0,0,0,1",
                     bus.out_valid, bus.n_rec, bus.err, bus.d_zero, bus.in_ready);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            $display("FAIL reset_mid_release: got ir=%b ov=%b exp ir=1 ov=0",
                     bus.in_ready, bus.out_valid);
        else n_pass++;
        run_check("after_reset", 8'd2, 8'd2, 8'd1, 16'd5);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] q, d, r;
            q = W'($urandom);
            d = W'($urandom);
            r = W'($urandom);
            run_check("b2b", q, d, r, (2*W)'($urandom));
            n_total++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
                $display("FAIL b2b_ready: got ir=%b ov=%b exp ir=1 ov=0",
                         bus.in_ready, bus.out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_vectors();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
